cdb_sched: RTL and testbench



---
 rtl/ooop_types.sv | 41 ++++
 rtl/cdb_fifo.sv | 55 +++++
 rtl/cdb_sched.sv | 125 ++++++++++++
 tb/tb_cdb_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ooop_types.sv
// Shared types for the out-of-order core: CDB packet, FU identifiers, source count.
package ooop_types;

    localparam int NUM_CDB_SRC = 3;
    localparam int CDB_TAG_W   = 7;
    localparam int CDB_PRD_W   = 7;
    localparam int CDB_DATA_W  = 32;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_BRU = 2'd2
    } fu_id_e;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  rob_tag;
        logic [CDB_PRD_W-1:0]  prd;
        logic [CDB_DATA_W-1:0] data;
    } cdb_pkt_t;

    // Results that do not write a register broadcast prd 0 so consumers never wake on it.
    function automatic cdb_pkt_t mk_pkt(logic [CDB_TAG_W-1:0] tag, logic [CDB_PRD_W-1:0] prd,
                                        logic [CDB_DATA_W-1:0] data, logic rd_used);
        cdb_pkt_t p;
        p.rob_tag = tag;
        p.prd     = rd_used ? prd : '0;
        p.data    = data;
        return p;
    endfunction

    function automatic fu_id_e fu_next(fu_id_e f);
        fu_id_e n;
        case (f)
            FU_ALU:  n = FU_LSU;
            FU_LSU:  n = FU_BRU;
            default: n = FU_ALU;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// QDEPTH-entry completion queue of CDB packets; flush clears pointers and count.
module cdb_fifo
    import ooop_types::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  cdb_pkt_t                wdata,
    input  logic                    pop,
    output cdb_pkt_t                rdata,
    output logic [$clog2(QDEPTH):0] count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(QDEPTH);

    cdb_pkt_t       mem [QDEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           do_push, do_pop;

    assign full    = (count == (AW+1)'(QDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count marks them valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cdb_sched.sv
// CDB scheduler: three FU completion queues, arbiter and registered broadcast.
// CDB_RR_EN selects round-robin arbitration; otherwise fixed priority ALU > LSU > BRU.
module cdb_sched
    import ooop_types::*;
#(
    parameter int QDEPTH = 2,
    parameter int TAG_W  = CDB_TAG_W,
    parameter int PRD_W  = CDB_PRD_W,
    parameter int DATA_W = CDB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              alu_valid_i,
    output logic              alu_ready_o,
    input  logic [TAG_W-1:0]  alu_rob_tag_i,
    input  logic [PRD_W-1:0]  alu_prd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_rd_used_i,
    input  logic              lsu_valid_i,
    output logic              lsu_ready_o,
    input  logic [TAG_W-1:0]  lsu_rob_tag_i,
    input  logic [PRD_W-1:0]  lsu_prd_i,
    input  logic [DATA_W-1:0] lsu_data_i,
    input  logic              lsu_rd_used_i,
    input  logic              bru_valid_i,
    output logic              bru_ready_o,
    input  logic [TAG_W-1:0]  bru_rob_tag_i,
    input  logic [PRD_W-1:0]  bru_prd_i,
    input  logic [DATA_W-1:0] bru_data_i,
    input  logic              bru_rd_used_i,
    output logic              cdb_valid_o,
    output logic [TAG_W-1:0]  cdb_rob_tag_o,
    output logic [PRD_W-1:0]  cdb_prd_o,
    output logic [DATA_W-1:0] cdb_data_o
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic     [NUM_CDB_SRC-1:0]         valid, ready, push, pop, full, empty;
    logic     [NUM_CDB_SRC-1:0][CW-1:0] count;
    cdb_pkt_t [NUM_CDB_SRC-1:0]         in_pkt, head;

    logic     any_gnt;
    fu_id_e   gnt_id;
    cdb_pkt_t cdb_q;
    logic     cdb_vld_q;

    assign valid          = {bru_valid_i, lsu_valid_i, alu_valid_i};
    assign in_pkt[FU_ALU] = mk_pkt(alu_rob_tag_i, alu_prd_i, alu_data_i, alu_rd_used_i);
    assign in_pkt[FU_LSU] = mk_pkt(lsu_rob_tag_i, lsu_prd_i, lsu_data_i, lsu_rd_used_i);
    assign in_pkt[FU_BRU] = mk_pkt(bru_rob_tag_i, bru_prd_i, bru_data_i, bru_rd_used_i);
    assign {bru_ready_o, lsu_ready_o, alu_ready_o} = ready;

    for (genvar i = 0; i < NUM_CDB_SRC; i++) begin : g_q
        // ready looks only at the registered count, never at this cycle's pop.
        assign ready[i] = (count[i] < CW'(QDEPTH));
        assign push[i]  = valid[i] && !full[i] && !flush_i;
        assign pop[i]   = any_gnt && (gnt_id == fu_id_e'(i)) && !flush_i;

        cdb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush_i),
            .push  (push[i]),
            .wdata (in_pkt[i]),
            .pop   (pop[i]),
            .rdata (head[i]),
            .count (count[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

`ifdef CDB_RR_EN
    fu_id_e rr_ptr;
    fu_id_e idx;

    always_comb begin
        any_gnt = 1'b0;
        gnt_id  = FU_ALU;
        idx     = rr_ptr;
        for (int k = 0; k < NUM_CDB_SRC; k++) begin
            if (!any_gnt && !empty[idx]) begin
                any_gnt = 1'b1;
                gnt_id  = idx;
            end
            idx = fu_next(idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rr_ptr <= FU_ALU;
        else if (flush_i) rr_ptr <= FU_ALU;
        else if (any_gnt) rr_ptr <= fu_next(gnt_id);
    end
`else
    always_comb begin
        any_gnt = 1'b1;
        gnt_id  = FU_ALU;
        if (!empty[FU_ALU])      gnt_id  = FU_ALU;
        else if (!empty[FU_LSU]) gnt_id  = FU_LSU;
        else if (!empty[FU_BRU]) gnt_id  = FU_BRU;
        else                     any_gnt = 1'b0;
    end
`endif

    // Payload holds across idle cycles; only the valid bit drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_vld_q <= 1'b0;
            cdb_q     <= '0;
        end else if (flush_i) begin
            cdb_vld_q <= 1'b0;
        end else begin
            cdb_vld_q <= any_gnt;
            if (any_gnt) cdb_q <= head[gnt_id];
        end
    end

    assign cdb_valid_o   = cdb_vld_q;
    assign cdb_rob_tag_o = cdb_q.rob_tag;
    assign cdb_prd_o     = cdb_q.prd;
    assign cdb_data_o    = cdb_q.data;

endmodule

// File: tb/tb_cdb_sched.sv
// Directed bench for cdb_sched; expected grant sequences follow the CDB_RR_EN setting.
module tb_cdb_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        alu_valid_i = 0, lsu_valid_i = 0, bru_valid_i = 0;
    logic        alu_ready_o, lsu_ready_o, bru_ready_o;
    logic [6:0]  alu_rob_tag_i = 0, lsu_rob_tag_i = 0, bru_rob_tag_i = 0;
    logic [6:0]  alu_prd_i = 0, lsu_prd_i = 0, bru_prd_i = 0;
    logic [31:0] alu_data_i = 0, lsu_data_i = 0, bru_data_i = 0;
    logic        alu_rd_used_i = 0, lsu_rd_used_i = 0, bru_rd_used_i = 0;
    logic        cdb_valid_o;
    logic [6:0]  cdb_rob_tag_o, cdb_prd_o;
    logic [31:0] cdb_data_o;

    int total = 0;
    int bad   = 0;
    int exp_tag  [16];
    int exp_lrdy [16];

    cdb_sched dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rob_tag_i(alu_rob_tag_i),
        .alu_prd_i(alu_prd_i), .alu_data_i(alu_data_i), .alu_rd_used_i(alu_rd_used_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rob_tag_i(lsu_rob_tag_i),
        .lsu_prd_i(lsu_prd_i), .lsu_data_i(lsu_data_i), .lsu_rd_used_i(lsu_rd_used_i),
        .bru_valid_i(bru_valid_i), .bru_ready_o(bru_ready_o), .bru_rob_tag_i(bru_rob_tag_i),
        .bru_prd_i(bru_prd_i), .bru_data_i(bru_data_i), .bru_rd_used_i(bru_rd_used_i),
        .cdb_valid_o(cdb_valid_o), .cdb_rob_tag_o(cdb_rob_tag_o),
        .cdb_prd_o(cdb_prd_o), .cdb_data_o(cdb_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_flush();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
    endtask

    // Each FU offers n beats tagged base, base+1, ...; prd = tag+1, data = A000_0000|tag.
    task automatic run_seq(input string name, input int na, input int ba, input int nl,
                           input int bl, input int nb, input int bb, input int ncyc);
        int  ia = 0, il = 0, ib = 0;
        logic ra, rl, rb;
        logic [6:0] t;
        for (int c = 1; c <= ncyc; c++) begin
            alu_valid_i = (ia < na); t = 7'(ba + ia);
            alu_rob_tag_i = t; alu_prd_i = t + 7'd1; alu_data_i = 32'hA000_0000 | 32'(t); alu_rd_used_i = 1'b1;
            lsu_valid_i = (il < nl); t = 7'(bl + il);
            lsu_rob_tag_i = t; lsu_prd_i = t + 7'd1; lsu_data_i = 32'hA000_0000 | 32'(t); lsu_rd_used_i = 1'b1;
            bru_valid_i = (ib < nb); t = 7'(bb + ib);
            bru_rob_tag_i = t; bru_prd_i = t + 7'd1; bru_data_i = 32'hA000_0000 | 32'(t); bru_rd_used_i = 1'b1;
            ra = alu_ready_o; rl = lsu_ready_o; rb = bru_ready_o;
            step();
            if (alu_valid_i && ra) ia++;
            if (lsu_valid_i && rl) il++;
            if (bru_valid_i && rb) ib++;
            if (exp_tag[c] == 0)
                chk($sformatf("%s_c%0d_idle", name, c), 64'(cdb_valid_o), 64'(1'b0));
            else begin
                t = 7'(exp_tag[c]);
                chk($sformatf("%s_c%0d_cdb", name, c),
                    64'({cdb_valid_o, cdb_rob_tag_o, cdb_prd_o, cdb_data_o}),
                    64'({1'b1, t, t + 7'd1, 32'hA000_0000 | 32'(t)}));
            end
            if (exp_lrdy[c] >= 0)
                chk($sformatf("%s_c%0d_lsu_ready", name, c), 64'(lsu_ready_o), 64'(exp_lrdy[c]));
        end
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; bru_valid_i = 1'b0;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst_valid", 64'(cdb_valid_o), 64'(1'b0));
        chk("rst_fields", 64'({cdb_rob_tag_o, cdb_prd_o, cdb_data_o}), 64'(0));
        chk("rst_ready", 64'({alu_ready_o, lsu_ready_o, bru_ready_o}), 64'(3'b111));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single ALU beat: visible after the second edge, then idle with fields held
        alu_valid_i = 1'b1; alu_rob_tag_i = 7'd5; alu_prd_i = 7'd12;
        alu_data_i = 32'hDEAD_BEEF; alu_rd_used_i = 1'b1;
        step();
        alu_valid_i = 1'b0;
        chk("alu1_e1", 64'(cdb_valid_o), 64'(1'b0));
        step();
        chk("alu1_e2", 64'({cdb_valid_o, cdb_rob_tag_o, cdb_prd_o, cdb_data_o}),
            64'({1'b1, 7'd5, 7'd12, 32'hDEAD_BEEF}));
        step();
        chk("alu1_e3_valid", 64'(cdb_valid_o), 64'(1'b0));
        chk("alu1_e3_hold", 64'(cdb_data_o), 64'(32'hDEAD_BEEF));

        // BRU beat without a destination register broadcasts prd 0
        bru_valid_i = 1'b1; bru_rob_tag_i = 7'd33; bru_prd_i = 7'd9;
        bru_data_i = 32'h0000_1234; bru_rd_used_i = 1'b0;
        step();
        bru_valid_i = 1'b0;
        step();
        chk("bru_nord", 64'({cdb_valid_o, cdb_rob_tag_o, cdb_prd_o, cdb_data_o}),
            64'({1'b1, 7'd33, 7'd0, 32'h0000_1234}));
        step();

        // All three FUs push continuously
        for (int i = 0; i < 16; i++) begin exp_tag[i] = 0; exp_lrdy[i] = -1; end
`ifdef CDB_RR_EN
        exp_tag = '{0, 0, 'h10, 'h20, 'h30, 'h11, 'h21, 'h31, 'h12, 'h22, 'h32, 'h13, 0, 0, 0, 0};
`else
        exp_tag = '{0, 0, 'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h30, 'h31, 'h32, 0, 0, 0, 0};
`endif
        exp_lrdy[2] = 0;
        run_seq("all3", 4, 'h10, 3, 'h20, 3, 'h30, 12);
        chk("all3_bru_ready_end", 64'(bru_ready_o), 64'(1'b1));
        pulse_flush();

        // Full LSU queue: pop and offered push at the same edge
        for (int i = 0; i < 16; i++) begin exp_tag[i] = 0; exp_lrdy[i] = -1; end
`ifdef CDB_RR_EN
        exp_tag = '{0, 0, 'h50, 'h40, 'h51, 'h41, 'h52, 'h42, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_lrdy[2] = 0; exp_lrdy[3] = 1; exp_lrdy[4] = 0; exp_lrdy[5] = 1;
`else
        exp_tag = '{0, 0, 'h50, 'h51, 'h52, 'h40, 'h41, 'h42, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_lrdy[2] = 0; exp_lrdy[3] = 0; exp_lrdy[4] = 0; exp_lrdy[5] = 1; exp_lrdy[6] = 1;
`endif
        run_seq("lsufull", 3, 'h50, 3, 'h40, 0, 0, 8);

        // Flush with queued beats and a beat offered in the flush cycle
        alu_rd_used_i = 1'b1; lsu_rd_used_i = 1'b1;
        alu_valid_i = 1'b1; alu_rob_tag_i = 7'h60; lsu_valid_i = 1'b1; lsu_rob_tag_i = 7'h70;
        step();
        alu_rob_tag_i = 7'h61; lsu_rob_tag_i = 7'h71;
        step();
        alu_rob_tag_i = 7'h7F; lsu_valid_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; alu_valid_i = 1'b0;
        chk("flush_valid", 64'(cdb_valid_o), 64'(1'b0));
        chk("flush_ready", 64'({alu_ready_o, lsu_ready_o, bru_ready_o}), 64'(3'b111));
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("flush_idle%0d", c), 64'(cdb_valid_o), 64'(1'b0));
        end
        // After flush the search starts from ALU again
        for (int i = 0; i < 16; i++) begin exp_tag[i] = 0; exp_lrdy[i] = -1; end
        exp_tag[2] = 'h0A; exp_tag[3] = 'h0B;
        run_seq("postflush", 1, 'h0A, 1, 'h0B, 0, 0, 4);

        // Asynchronous reset mid-operation
        alu_valid_i = 1'b1; alu_rob_tag_i = 7'h77; alu_prd_i = 7'd3; alu_data_i = 32'h55; alu_rd_used_i = 1'b1;
        step();
        step();
        alu_valid_i = 1'b0;
        chk("mid_pre", 64'({cdb_valid_o, cdb_rob_tag_o}), 64'({1'b1, 7'h77}));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(cdb_valid_o), 64'(1'b0));
        chk("mid_rst_fields", 64'({cdb_rob_tag_o, cdb_prd_o, cdb_data_o}), 64'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("mid_post", 64'({cdb_valid_o, alu_ready_o, lsu_ready_o, bru_ready_o}), 64'(4'b0111));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
